// File: rtl/fifo_pop_demux.sv
// Pop-side demultiplexer: drains the upstream 6-bit FIFO and routes each word to one of four
// destinations by its top two bits. Optional DEMUX_STATS_EN builds the delivered-word counter.
module fifo_pop_demux #(
  parameter int unsigned DATA_W = 6,
  parameter int unsigned N_DEST = 4
) (
  input  logic              clk,
  input  logic              reset_L,
  input  logic              fifo_empty,
  input  logic [DATA_W-1:0] fifo_data,
  input  logic              fifo_valid,
  input  logic [N_DEST-1:0] dest_pause,
  input  logic [N_DEST-1:0] dest_continue,
  output logic              pop,
  output logic [N_DEST-1:0] push,
  output logic [DATA_W-1:0] data_out,
  output logic [N_DEST-1:0] blocked,
  output logic              idle,
  output logic [7:0]        word_count
);

  if (N_DEST != 4) begin : gen_bad_n_dest
    $error("fifo_pop_demux: N_DEST must be 4 (2-bit destination select)");
  end

  typedef enum logic [1:0] {
    StIdle,
    StActive,
    StPaused
  } state_e;

  state_e              state_q, state_d;
  logic [N_DEST-1:0]   blocked_q, blocked_d;
  logic [N_DEST-1:0]   push_q, push_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [1:0]          pop_hist_q;
  logic                armed_q;
  logic                any_blocked;
  logic [1:0]          dest_sel;

  assign any_blocked = |blocked_q;
  assign dest_sel    = fifo_data[DATA_W-1 -: 2];

  // Pause wins over continue when both arrive together.
  assign blocked_d = (blocked_q & ~dest_continue) | dest_pause;

  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (any_blocked) begin
          state_d = StPaused;
        end else if (!fifo_empty) begin
          state_d = StActive;
        end
      end
      StActive: begin
        pop = !fifo_empty && !any_blocked;
        if (any_blocked) begin
          state_d = StPaused;
        end else if (fifo_empty) begin
          state_d = StIdle;
        end
      end
      StPaused: begin
        if (!any_blocked) begin
          state_d = fifo_empty ? StIdle : StActive;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Words already requested are delivered regardless of blocking; armed_q drops the stale
  // return of a pop that was abandoned by reset.
  always_comb begin
    push_d = '0;
    data_d = data_q;
    if (fifo_valid && armed_q) begin
      push_d[dest_sel] = 1'b1;
      data_d           = fifo_data;
    end
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state_q    <= StIdle;
      blocked_q  <= '0;
      push_q     <= '0;
      data_q     <= '0;
      pop_hist_q <= '0;
      armed_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      blocked_q  <= blocked_d;
      push_q     <= push_d;
      data_q     <= data_d;
      pop_hist_q <= {pop_hist_q[0], pop};
      armed_q    <= 1'b1;
    end
  end

  assign push     = push_q;
  assign data_out = data_q;
  assign blocked  = blocked_q;
  // Held low until the first edge after reset so every output reads 0 in reset.
  assign idle     = (state_q == StIdle) && (pop_hist_q == 2'b00) && armed_q;

`ifdef DEMUX_STATS_EN
  logic [7:0] count_q;

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      count_q <= '0;
    end else if (|push_q) begin
      count_q <= count_q + 8'd1;
    end
  end

  assign word_count = count_q;
`else
  assign word_count = '0;
`endif

endmodule

// File: tb/tb_fifo_pop_demux.sv
// Directed, table-driven bench for fifo_pop_demux with a small upstream FIFO model.
module tb_fifo_pop_demux;

  logic       clk;
  logic       reset_L;
  logic       fifo_empty;
  logic [5:0] fifo_data;
  logic       fifo_valid;
  logic [3:0] dest_pause;
  logic [3:0] dest_continue;
  logic       pop;
  logic [3:0] push;
  logic [5:0] data_out;
  logic [3:0] blocked;
  logic       idle;
  logic [7:0] word_count;

  int n_chk  = 0;
  int n_fail = 0;

  logic [5:0] fq[$];
  logic [5:0] sb[$];

  typedef struct {
    logic [3:0] pause;
    logic [3:0] cont;
    logic       mask;
    logic       pop;
    logic [3:0] push;
    logic [5:0] data;
    logic [3:0] blocked;
    logic       idle;
  } vec_t;

  vec_t vecs[$];

  fifo_pop_demux #(
    .DATA_W(6),
    .N_DEST(4)
  ) dut (
    .clk          (clk),
    .reset_L      (reset_L),
    .fifo_empty   (fifo_empty),
    .fifo_data    (fifo_data),
    .fifo_valid   (fifo_valid),
    .dest_pause   (dest_pause),
    .dest_continue(dest_continue),
    .pop          (pop),
    .push         (push),
    .data_out     (data_out),
    .blocked      (blocked),
    .idle         (idle),
    .word_count   (word_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected end of test");
    $fatal(1);
  end

  task automatic chk(input string name, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s [%0d]: got 0x%0h expected 0x%0h", name, idx, act, exp);
    end
  endtask

  // One clock: pop is sampled mid-cycle, the FIFO model answers just after the edge.
  task automatic tick();
    logic p;
    @(negedge clk);
    p = pop;
    @(posedge clk);
    #1;
    fifo_valid = p;
    if (p && fq.size() > 0) fifo_data = fq.pop_front();
    fifo_empty    = (fq.size() == 0);
    dest_pause    = '0;
    dest_continue = '0;
  endtask

  function automatic void add(logic [3:0] pa, logic [3:0] co, logic m, logic p, logic [3:0] pu,
                              logic [5:0] d, logic [3:0] b, logic i);
    vecs.push_back('{pa, co, m, p, pu, d, b, i});
  endfunction

  task automatic run_vecs(input int first, input int last);
    for (int i = first; i <= last; i++) begin
      dest_pause    = vecs[i].pause;
      dest_continue = vecs[i].cont;
      fifo_empty    = (fq.size() == 0) | vecs[i].mask;
      #1;
      chk("pop", i, 32'(pop), 32'(vecs[i].pop));
      chk("push", i, 32'(push), 32'(vecs[i].push));
      chk("data_out", i, 32'(data_out), 32'(vecs[i].data));
      chk("blocked", i, 32'(blocked), 32'(vecs[i].blocked));
      chk("idle", i, 32'(idle), 32'(vecs[i].idle));
      tick();
    end
  endtask

  initial begin
    int got;
    logic [5:0] w;
    logic [7:0] exp_wc;

    // Stream of four words, one per destination
    add(4'h0, 4'h0, 0, 0, 4'b0000, 6'h00, 4'h0, 0);
    add(4'h0, 4'h0, 0, 1, 4'b0000, 6'h00, 4'h0, 0);
    add(4'h0, 4'h0, 0, 1, 4'b0000, 6'h00, 4'h0, 0);
    add(4'h0, 4'h0, 0, 1, 4'b0001, 6'h05, 4'h0, 0);
    add(4'h0, 4'h0, 0, 1, 4'b0010, 6'h1A, 4'h0, 0);
    add(4'h0, 4'h0, 0, 0, 4'b0100, 6'h2F, 4'h0, 0);
    add(4'h0, 4'h0, 0, 0, 4'b1000, 6'h30, 4'h0, 0);
    add(4'h0, 4'h0, 0, 0, 4'b0000, 6'h30, 4'h0, 1);
    // Pause on destination 2 mid-stream, then continue (vectors 8..21)
    add(4'h0, 4'h0, 0, 0, 4'b0000, 6'h30, 4'h0, 1);
    add(4'h0, 4'h0, 0, 1, 4'b0000, 6'h30, 4'h0, 0);
    add(4'h4, 4'h0, 0, 1, 4'b0000, 6'h30, 4'h0, 0);
    add(4'h0, 4'h0, 0, 0, 4'b0001, 6'h01, 4'h4, 0);
    add(4'h0, 4'h0, 0, 0, 4'b0010, 6'h12, 4'h4, 0);
    add(4'h0, 4'h4, 0, 0, 4'b0000, 6'h12, 4'h4, 0);
    add(4'h0, 4'h0, 0, 0, 4'b0000, 6'h12, 4'h0, 0);
    add(4'h0, 4'h0, 0, 1, 4'b0000, 6'h12, 4'h0, 0);
    add(4'h0, 4'h0, 0, 1, 4'b0000, 6'h12, 4'h0, 0);
    add(4'h0, 4'h0, 0, 1, 4'b0100, 6'h23, 4'h0, 0);
    add(4'h0, 4'h0, 0, 1, 4'b1000, 6'h34, 4'h0, 0);
    add(4'h0, 4'h0, 0, 0, 4'b0001, 6'h05, 4'h0, 0);
    add(4'h0, 4'h0, 0, 0, 4'b0010, 6'h16, 4'h0, 0);
    add(4'h0, 4'h0, 0, 0, 4'b0000, 6'h16, 4'h0, 1);
    // Simultaneous pause and continue on destination 1 (vectors 22..26)
    add(4'h2, 4'h2, 0, 0, 4'b0000, 6'h16, 4'h0, 1);
    add(4'h0, 4'h0, 0, 0, 4'b0000, 6'h16, 4'h2, 1);
    add(4'h0, 4'h2, 0, 0, 4'b0000, 6'h16, 4'h2, 0);
    add(4'h0, 4'h0, 0, 0, 4'b0000, 6'h16, 4'h0, 0);
    add(4'h0, 4'h0, 0, 0, 4'b0000, 6'h16, 4'h0, 1);
    // fifo_empty toggling (vectors 27..34)
    add(4'h0, 4'h0, 0, 0, 4'b0000, 6'h16, 4'h0, 1);
    add(4'h0, 4'h0, 0, 1, 4'b0000, 6'h16, 4'h0, 0);
    add(4'h0, 4'h0, 1, 0, 4'b0000, 6'h16, 4'h0, 0);
    add(4'h0, 4'h0, 0, 0, 4'b1000, 6'h3A, 4'h0, 0);
    add(4'h0, 4'h0, 1, 0, 4'b0000, 6'h3A, 4'h0, 0);
    add(4'h0, 4'h0, 0, 0, 4'b0000, 6'h3A, 4'h0, 1);
    add(4'h0, 4'h0, 1, 0, 4'b0000, 6'h3A, 4'h0, 0);
    add(4'h0, 4'h0, 1, 0, 4'b0000, 6'h3A, 4'h0, 1);

    reset_L       = 1'b0;
    fifo_empty    = 1'b1;
    fifo_data     = '0;
    fifo_valid    = 1'b0;
    dest_pause    = '0;
    dest_continue = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_pop", 0, 32'(pop), 0);
    chk("rst_push", 0, 32'(push), 0);
    chk("rst_data", 0, 32'(data_out), 0);
    chk("rst_idle", 0, 32'(idle), 0);
    chk("rst_wc", 0, 32'(word_count), 0);

    fq = '{6'h05, 6'h1A, 6'h2F, 6'h30};
    reset_L = 1'b1;
    run_vecs(0, 7);
    fq = '{6'h01, 6'h12, 6'h23, 6'h34, 6'h05, 6'h16};
    run_vecs(8, 21);
    run_vecs(22, 26);
    fq = '{6'h3A, 6'h07, 6'h28};
    run_vecs(27, 34);
    fq.delete();
    fifo_empty = 1'b1;

    // Reset between pop and the returning word
    fq = '{6'h25};
    fifo_empty = 1'b0;
    #1;
    tick();
    #1;
    chk("e_pop", 1, 32'(pop), 1);
    @(negedge clk);
    #1 reset_L = 1'b0;
    #1;
    chk("e_rst_pop", 0, 32'(pop), 0);
    chk("e_rst_push", 0, 32'(push), 0);
    chk("e_rst_data", 0, 32'(data_out), 0);
    chk("e_rst_blocked", 0, 32'(blocked), 0);
    chk("e_rst_idle", 0, 32'(idle), 0);
    @(posedge clk);
    #1;
    fifo_valid = 1'b1;
    fifo_data  = fq.pop_front();
    fifo_empty = 1'b1;
    reset_L    = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      #1;
      chk("e_push", k, 32'(push), 0);
      chk("e_data", k, 32'(data_out), 0);
      chk("e_wc", k, 32'(word_count), 0);
    end

    // Long stream to exercise the counter wrap
    for (int i = 0; i < 260; i++) begin
      w = 6'(i * 7);
      fq.push_back(w);
      sb.push_back(w);
    end
    fifo_empty = 1'b0;
    got = 0;
    for (int cyc = 0; cyc < 400 && got < 260; cyc++) begin
      tick();
      #1;
      if (push != 4'b0000) begin
        w = sb.pop_front();
        chk("f_push", got, 32'(push), 32'(4'b0001 << w[5:4]));
        chk("f_data", got, 32'(data_out), 32'(w));
        got++;
      end
    end
    chk("f_delivered", 0, 32'(got), 260);
    repeat (2) begin
      tick();
      #1;
    end
    chk("f_push_after", 0, 32'(push), 0);
`ifdef DEMUX_STATS_EN
    exp_wc = 8'd4;
`else
    exp_wc = 8'd0;
`endif
    chk("f_word_count", 0, 32'(word_count), 32'(exp_wc));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
